xmem_part_decode: RTL
=====================

Name: xmem_part_decode

Overview:
- Upstream stage of the xmem bank-address calculator. Accepts global-address requests over valid/ready and finds the owning partition by range compare against a RISC-programmed table.
- Emits the request with `partIdx`, an in-range flag and the bank select. The consumer feeds these into bank-address calculation and the bank crossbar.
- Two-stage pipeline with full throughput and a saturating miss counter.

Parameters:
- `RANGE_TYPE`, "SCALAR", selects bank-select rule: "SCALAR", "ARRAY" or "CYCLIC".
- `NUM_PART`, `MAX_PARTITION`, number of populated table entries (≤ `MAX_PARTITION`).
- `TAG_W`, 8, width of the opaque request tag carried alongside the address.
- `BANK_SEL_W`, `LOG2_BANK_NUM`, width of the bank-select output.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_we` in 1: table write strobe from RISC.
- `cfg_idx` in `LOG2_MAX_PARTITION`: entry to write.
- `cfg_start` in `XMEM_AW`: inclusive range start.
- `cfg_end` in `XMEM_AW`: exclusive range end.
- `cfg_bank_shift` in 5: log2 of sub-bank size for the entry (ARRAY/CYCLIC).
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid` and `in_ready` are both high.
- `in_adr` in `XMEM_AW`: global address.
- `in_tag` in `TAG_W`: passthrough tag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer ready.
- `out_adr` out `XMEM_AW`: address, unchanged.
- `out_tag` out `TAG_W`: tag, unchanged.
- `out_partIdx` out `LOG2_MAX_PARTITION`: owning partition.
- `out_hit` out 1: address matched an entry.
- `out_bankSel` out `BANK_SEL_W`: target bank.
- `miss_cnt` out 16: saturating count of issued misses.

Behaviour:
- Reset clears the table to start=0 / end=0 (no hits), both stage valids and `miss_cnt`. While `rst` is high: `out_valid`=0, `in_ready`=0 and all data outputs are 0.
- Table:
  - `cfg_we` writes entry `cfg_idx` at the clock edge.
  - A write with `cfg_idx` ≥ `NUM_PART` is ignored.
  - A request accepted in the same cycle as a write sees the old entry. Requests accepted one cycle later see the new entry.
- Stage 1 (S1), registered on accept:
  - Parallel compare `start[i]` ≤ adr < `end[i]` for every i < `NUM_PART`. The lowest matching i wins.
  - S1 captures adr, tag, hit, partIdx, and the winning entry's `start` and `bank_shift`.
  - No match → hit=0, partIdx=0.
- Stage 2 (S2) registers the bank select:
  - SCALAR: `(adr>>2) mod BANK_NUM[MEM_TYPE_SCALAR]`.
  - ARRAY: `((adr-start) >> bank_shift)`, truncated to `BANK_SEL_W`.
  - CYCLIC: `((adr-start)>>2)`, low `BANK_SEL_W` bits.
  - All subtraction is unsigned, modulo 2^`XMEM_AW`.
  - On a miss, `out_bankSel`=0.
- Handshake:
  - S2 loads from S1 when S2 is empty or `out_ready`=1.
  - S1 loads when S1 is empty or S1 advances.
  - `in_ready` = !S1_valid | S1_advances. This is combinational from `out_ready`, with no bubbles.
  - Latency: 2 cycles from accept to `out_valid`. Sustained 1 req/cycle with `out_ready` held high.
  - When `out_valid`=1 and `out_ready`=0, all `out_*` hold stable.
- `miss_cnt` increments when `out_valid` & `out_ready` & !`out_hit`. It saturates at 0xFFFF.
- `rst` asserted mid-stream drops both stages' contents. There is no partial output.
- The end=start entry is empty and never matches.

Decomposition:
- `LOG2_BANK_NUM` and the `RANGE_TYPE` string constants go into `xmem_param_pkg`, alongside `XMEM_AW`, `MAX_PARTITION`, `LOG2_MAX_PARTITION` and `BANK_NUM`.
- Package a `part_entry_t` struct holding start, end and bank_shift.
- One sub-module, `part_match`: purely combinational priority compare returning hit and partIdx.

Test Plan:
- Program p0=[0x1000,0x2000), p1=[0x1800,0x3000); send 0x1900 → `out_partIdx`=0, `out_hit`=1, two cycles after accept.
- Send 0x4000 with no covering entry → `out_hit`=0, `out_partIdx`=0, `out_bankSel`=0, `miss_cnt`=1.
- SCALAR, BANK_NUM=4: stream 0x00, 0x04, 0x08, 0x0C, 0x10 back-to-back → `out_bankSel` 0, 1, 2, 3, 0, with one output per cycle.
- Hold `out_ready`=0 for 5 cycles with 3 requests offered → only 2 accepted; outputs stable throughout. On release, all 3 emerge in order with tags intact.
- Write p0=[0,0x100) in the same cycle a request for 0x80 is accepted, with p0 previously empty → miss. A repeat of 0x80 next cycle → hit on p0.
- Assert `rst` with both stages full → `out_valid`=0 next cycle, `miss_cnt`=0, and the table is cleared (0x1900 now misses).

Source files
------------

// File: rtl/xmem_param_pkg.sv
// Shared xmem parameters, range-type names and the partition table entry type.
package xmem_param_pkg;

    localparam int XMEM_AW            = 32;
    localparam int MAX_PARTITION      = 8;
    localparam int LOG2_MAX_PARTITION = 3;
    localparam int LOG2_BANK_NUM      = 2;

    // Memory flavours; BANK_NUM is indexed by these.
    typedef enum logic [1:0] {
        MEM_TYPE_SCALAR = 2'd0,
        MEM_TYPE_ARRAY  = 2'd1,
        MEM_TYPE_CYCLIC = 2'd2
    } mem_type_e;

    localparam int BANK_NUM [3] = '{4, 4, 4};

    // Bank-select rule names for the RANGE_TYPE parameter.
    localparam string RANGE_SCALAR = "SCALAR";
    localparam string RANGE_ARRAY  = "ARRAY";
    localparam string RANGE_CYCLIC = "CYCLIC";

    // One partition: [start_adr, end_adr) plus log2 of its sub-bank size.
    typedef struct packed {
        logic [XMEM_AW-1:0] start_adr;
        logic [XMEM_AW-1:0] end_adr;
        logic [4:0]         bank_shift;
    } part_entry_t;

endpackage

// File: rtl/part_match.sv
// Combinational priority range compare: lowest-index entry covering adr wins.
module part_match
    import xmem_param_pkg::*;
#(
    parameter int NUM_PART = MAX_PARTITION
) (
    input  logic [XMEM_AW-1:0]                adr_i,
    input  logic [NUM_PART-1:0][XMEM_AW-1:0]  start_i,
    input  logic [NUM_PART-1:0][XMEM_AW-1:0]  end_i,
    output logic                              hit_o,
    output logic [LOG2_MAX_PARTITION-1:0]     idx_o
);

    // Walk from the top entry down so the lowest match is the one left standing.
    // An entry with end <= start can never satisfy both compares.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_PART - 1; i >= 0; i--) begin
            if ((start_i[i] <= adr_i) && (adr_i < end_i[i])) begin
                hit_o = 1'b1;
                idx_o = LOG2_MAX_PARTITION'(i);
            end
        end
    end

endmodule

// File: rtl/xmem_part_decode.sv
// xmem partition decode: range lookup (S1) then bank select (S2), valid/ready
// on both sides, full throughput, saturating count of issued misses.
module xmem_part_decode
    import xmem_param_pkg::*;
#(
    parameter string RANGE_TYPE = RANGE_SCALAR,
    parameter int    NUM_PART   = MAX_PARTITION,
    parameter int    TAG_W      = 8,
    parameter int    BANK_SEL_W = LOG2_BANK_NUM
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [LOG2_MAX_PARTITION-1:0] cfg_idx,
    input  logic [XMEM_AW-1:0]            cfg_start,
    input  logic [XMEM_AW-1:0]            cfg_end,
    input  logic [4:0]                    cfg_bank_shift,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [XMEM_AW-1:0]            in_adr,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XMEM_AW-1:0]            out_adr,
    output logic [TAG_W-1:0]              out_tag,
    output logic [LOG2_MAX_PARTITION-1:0] out_partIdx,
    output logic                          out_hit,
    output logic [BANK_SEL_W-1:0]         out_bankSel,
    output logic [15:0]                   miss_cnt
);

    localparam int SCALAR_BANKS = BANK_NUM[MEM_TYPE_SCALAR];
    localparam int RT_SEL = (RANGE_TYPE == RANGE_ARRAY)  ? 1 :
                            (RANGE_TYPE == RANGE_CYCLIC) ? 2 : 0;

    part_entry_t tbl_q [NUM_PART];

    logic [NUM_PART-1:0][XMEM_AW-1:0] m_start, m_end;
    logic                             m_hit;
    logic [LOG2_MAX_PARTITION-1:0]    m_idx;
    logic [XMEM_AW-1:0]               win_start;
    logic [4:0]                       win_shift;

    logic                          s1_vld_q, s1_hit_q;
    logic [XMEM_AW-1:0]            s1_adr_q, s1_start_q;
    logic [TAG_W-1:0]              s1_tag_q;
    logic [LOG2_MAX_PARTITION-1:0] s1_idx_q;
    logic [4:0]                    s1_shift_q;

    logic                          s2_vld_q, s2_hit_q;
    logic [XMEM_AW-1:0]            s2_adr_q;
    logic [TAG_W-1:0]              s2_tag_q;
    logic [LOG2_MAX_PARTITION-1:0] s2_idx_q;
    logic [BANK_SEL_W-1:0]         s2_bsel_q, bsel_d;
    logic [XMEM_AW-1:0]            offs;

    logic [15:0] miss_cnt_q;
    logic        s2_load, s1_adv, in_fire;

    // Table write from RISC; indices at or above NUM_PART match no entry and drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PART; i++) tbl_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PART; i++) begin
                if (cfg_we && (cfg_idx == LOG2_MAX_PARTITION'(i)))
                    tbl_q[i] <= '{start_adr: cfg_start, end_adr: cfg_end, bank_shift: cfg_bank_shift};
            end
        end
    end

    // Flatten the table bounds for the comparator.
    always_comb begin
        for (int i = 0; i < NUM_PART; i++) begin
            m_start[i] = tbl_q[i].start_adr;
            m_end[i]   = tbl_q[i].end_adr;
        end
    end

    part_match #(.NUM_PART(NUM_PART)) u_match (
        .adr_i   (in_adr),
        .start_i (m_start),
        .end_i   (m_end),
        .hit_o   (m_hit),
        .idx_o   (m_idx)
    );

    // Fetch start/shift of the winning entry (entry 0 on a miss; masked later).
    always_comb begin
        win_start = '0;
        win_shift = '0;
        for (int i = 0; i < NUM_PART; i++) begin
            if (m_idx == LOG2_MAX_PARTITION'(i)) begin
                win_start = tbl_q[i].start_adr;
                win_shift = tbl_q[i].bank_shift;
            end
        end
    end

    // Handshake: S2 drains on out_ready, S1 drains into S2, ready ripples back
    // combinationally so a full pipe still takes one request per cycle.
    assign s2_load  = !s2_vld_q || out_ready;
    assign s1_adv   = s1_vld_q && s2_load;
    assign in_ready = !rst && (!s1_vld_q || s1_adv);
    assign in_fire  = in_valid && in_ready;

    // S1: capture the request together with its lookup result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_adr_q   <= '0;
            s1_start_q <= '0;
            s1_tag_q   <= '0;
            s1_idx_q   <= '0;
            s1_shift_q <= '0;
        end else begin
            if (in_ready) s1_vld_q <= in_valid;
            if (in_fire) begin
                s1_hit_q   <= m_hit;
                s1_adr_q   <= in_adr;
                s1_tag_q   <= in_tag;
                s1_idx_q   <= m_hit ? m_idx : '0;
                s1_start_q <= win_start;
                s1_shift_q <= win_shift;
            end
        end
    end

    // Bank select per range type; offsets wrap modulo 2^XMEM_AW.
    always_comb begin
        offs = s1_adr_q - s1_start_q;
        if (RT_SEL == 1)
            bsel_d = BANK_SEL_W'(offs >> s1_shift_q);
        else if (RT_SEL == 2)
            bsel_d = BANK_SEL_W'(offs >> 2);
        else
            bsel_d = BANK_SEL_W'((s1_adr_q >> 2) % XMEM_AW'(SCALAR_BANKS));
        if (!s1_hit_q) bsel_d = '0;
    end

    // S2: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_hit_q  <= 1'b0;
            s2_adr_q  <= '0;
            s2_tag_q  <= '0;
            s2_idx_q  <= '0;
            s2_bsel_q <= '0;
        end else if (s2_load) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_hit_q  <= s1_hit_q;
                s2_adr_q  <= s1_adr_q;
                s2_tag_q  <= s1_tag_q;
                s2_idx_q  <= s1_idx_q;
                s2_bsel_q <= bsel_d;
            end
        end
    end

    // Count misses as they are handed off, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            miss_cnt_q <= '0;
        else if (s2_vld_q && out_ready && !s2_hit_q && (miss_cnt_q != 16'hFFFF))
            miss_cnt_q <= miss_cnt_q + 16'd1;
    end

    // Outputs are forced quiet for the whole time reset is held.
    assign out_valid   = s2_vld_q && !rst;
    assign out_hit     = s2_hit_q && !rst;
    assign out_adr     = rst ? '0 : s2_adr_q;
    assign out_tag     = rst ? '0 : s2_tag_q;
    assign out_partIdx = rst ? '0 : s2_idx_q;
    assign out_bankSel = rst ? '0 : s2_bsel_q;
    assign miss_cnt    = rst ? '0 : miss_cnt_q;

endmodule
